// File: rtl/gauss_line_buffer_pkg.sv
// Shared parameters and state encoding for the 5x5 Gaussian line buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: default image geometry, counter width, number of line RAMs,
// and the FSM state type used by gauss_line_buffer.
package gauss_line_buffer_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int ROW_DEF        = 480;
  localparam int COL_DEF        = 752;
  localparam int FLUSH_ROWS_DEF = 3;
  localparam int CNT_W          = 10;
  localparam int TAPS           = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/gauss_line_buffer_line_ram.sv
// One image line of storage: single-port RAM, synchronous read-before-write.
// Latency: 1 clock from addr to rd_dat (old contents at addr).
// Backpressure: none; one access per clock.
//
// Ports: clk; addr (column); wr_en/wr_dat write the addressed word;
// rd_dat is the registered word that was stored at addr before the write.
module gauss_line_buffer_line_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 752,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    rd_dat <= mem[addr];
    if (wr_en) begin
      mem[addr] <= wr_dat;
    end
  end

endmodule

// File: rtl/gauss_line_buffer.sv
// Raster-to-column converter feeding the 5x5 Gaussian kernel: five aligned row taps plus position.
// Latency: 1 clock from pix_in to din_4 (and to the matching din_3..din_0, row_cnt, col_cnt).
// Backpressure: none; the stream must be continuous, a missing pix_valid in a frame only sets err.
//
// Ports: clk, en (sync active-low reset), frame_start/pix_valid/pix_in in;
// din_4 (newest row) .. din_0 (oldest row), row_cnt, col_cnt, dvalid,
// busy (FSM not idle) and sticky err out.
module gauss_line_buffer
  import gauss_line_buffer_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ROW        = ROW_DEF,
  parameter int COL        = COL_DEF,
  parameter int FLUSH_ROWS = FLUSH_ROWS_DEF
) (
  input  logic             clk,
  input  logic             en,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [WIDTH-1:0] pix_in,
  output logic [WIDTH-1:0] din_4,
  output logic [WIDTH-1:0] din_3,
  output logic [WIDTH-1:0] din_2,
  output logic [WIDTH-1:0] din_1,
  output logic [WIDTH-1:0] din_0,
  output logic [CNT_W-1:0] row_cnt,
  output logic [CNT_W-1:0] col_cnt,
  output logic             dvalid,
  output logic             busy,
  output logic             err
);

  localparam int AW = (COL > 1) ? $clog2(COL) : 1;
  localparam logic [CNT_W-1:0] LAST_COL       = CNT_W'(COL - 1);
  localparam logic [CNT_W-1:0] LAST_ROW       = CNT_W'(ROW - 1);
  localparam logic [CNT_W-1:0] LAST_FLUSH_ROW = CNT_W'(ROW + FLUSH_ROWS - 1);

  state_t           state;
  logic [CNT_W-1:0] col;     // column of the position processed this cycle
  logic [CNT_W-1:0] row;     // row of the position processed this cycle
  logic [WIDTH-1:0] pix_q;
  logic [WIDTH-1:0] ram_q [TAPS];

  logic             start;
  logic             proc;
  logic             col_wrap;
  logic             end_active;
  logic             end_frame;
  logic [WIDTH-1:0] new_pix;

  // col/row sit at 0 while idle, so an accepted frame_start processes (0,0)
  // in the same cycle without a separate load path.
  always_comb begin
    start      = (state == IDLE) && frame_start && pix_valid;
    proc       = start || (state != IDLE);
    col_wrap   = (col == LAST_COL);
    end_active = (row == LAST_ROW) && col_wrap;
    end_frame  = (row == LAST_FLUSH_ROW) && col_wrap;
    new_pix    = (state == FLUSH) ? '0 : pix_in;
  end

  // The four lines rotate instead of physically cascading: the line being
  // written is row mod 4, and its read-before-write data is the line four
  // rows up. The other three hold rows r-1..r-3 at the same column, which
  // gives the same taps as shifting every line down each row, with single-
  // port RAMs and no extra write path between them.
  for (genvar i = 0; i < TAPS; i++) begin : g_line
    localparam logic [1:0] SLOT = 2'(i);

    gauss_line_buffer_line_ram #(
      .WIDTH (WIDTH),
      .DEPTH (COL),
      .AW    (AW)
    ) u_ram (
      .clk    (clk),
      .addr   (col[AW-1:0]),
      .wr_en  (proc && (row[1:0] == SLOT)),
      .wr_dat (new_pix),
      .rd_dat (ram_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!en) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      pix_q   <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      dvalid  <= 1'b0;
      err     <= 1'b0;
    end else begin
      dvalid  <= proc;
      row_cnt <= proc ? row : '0;
      col_cnt <= proc ? col : '0;
      pix_q   <= proc ? new_pix : '0;

      if (proc) begin
        if (end_frame) begin
          state <= IDLE;
          col   <= '0;
          row   <= '0;
        end else begin
          if (end_active) begin
            state <= FLUSH;
          end else if (state == IDLE) begin
            state <= ACTIVE;
          end
          col <= col_wrap ? '0 : col + 1'b1;
          if (col_wrap) begin
            row <= row + 1'b1;
          end
        end
      end

      // A gap in the active stream cannot be stalled downstream, and a
      // frame_start while busy (including the last flush cycle) is dropped.
      if (((state == ACTIVE) && !pix_valid) || ((state != IDLE) && frame_start)) begin
        err <= 1'b1;
      end
    end
  end

  // Output row selects the rotation slot; taps from rows above the top of
  // the frame are masked, which also hides stale lines from earlier frames.
  logic [1:0] slot;
  always_comb begin
    slot  = row_cnt[1:0];
    din_4 = pix_q;
    din_3 = (dvalid && (row_cnt >= CNT_W'(1))) ? ram_q[slot - 2'd1] : '0;
    din_2 = (dvalid && (row_cnt >= CNT_W'(2))) ? ram_q[slot - 2'd2] : '0;
    din_1 = (dvalid && (row_cnt >= CNT_W'(3))) ? ram_q[slot - 2'd3] : '0;
    din_0 = (dvalid && (row_cnt >= CNT_W'(4))) ? ram_q[slot]        : '0;
  end

  assign busy = (state != IDLE);

endmodule
